// File: rtl/axis_ema_inv.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ema_inv
//  Description : AXI4-Stream inverse EMA (de-emphasis decoder). Recovers
//                x[n] from y[n] = y[n-1] + ((x[n]-y[n-1]) >>> SHIFT) by
//                computing x = y_prev + ((y - y_prev) <<< SHIFT), saturated.
//                One beat per cycle, registered output stage plus skid.
//  Revision    : 1.0  initial release
// ============================================================================
module axis_ema_inv #(
  parameter int DATA_W = 32,
  parameter int SHIFT  = 3
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY
);

  localparam int KEEP_W = DATA_W / 8;
  // Headroom: difference needs DATA_W+1 bits, the shift adds SHIFT, the
  // final addition one more.
  localparam int EXT_W  = DATA_W + SHIFT + 2;

  localparam logic signed [EXT_W-1:0] c_sat_max = {{(SHIFT+3){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] c_sat_min = {{(SHIFT+3){1'b1}}, {(DATA_W-1){1'b0}}};

  // Decoder state: last non-null sample of the current packet
  logic [DATA_W-1:0]        r_y_prev;

  // Output register
  logic                     r_out_valid;
  logic [DATA_W-1:0]        r_out_data;
  logic [KEEP_W-1:0]        r_out_keep;
  logic                     r_out_last;

  // Skid register
  logic                     r_skid_valid;
  logic [DATA_W-1:0]        r_skid_data;
  logic [KEEP_W-1:0]        r_skid_keep;
  logic                     r_skid_last;

  logic                     r_s_ready;

  logic signed [EXT_W-1:0]  w_y_ext;
  logic signed [EXT_W-1:0]  w_prev_ext;
  logic signed [EXT_W-1:0]  w_diff;
  logic signed [EXT_W-1:0]  w_x_ext;
  logic [DATA_W-1:0]        w_x_sat;
  logic                     w_is_null;
  logic [DATA_W-1:0]        w_beat_data;
  logic                     w_accept;
  logic                     w_out_free;
  logic                     w_skid_valid_next;

  // Reconstruct the unfiltered sample for the beat currently on S_AXIS
  always_comb begin
    w_y_ext    = {{(SHIFT+2){S_AXIS_TDATA[DATA_W-1]}}, S_AXIS_TDATA};
    w_prev_ext = {{(SHIFT+2){r_y_prev[DATA_W-1]}}, r_y_prev};
    w_diff     = w_y_ext - w_prev_ext;
    w_x_ext    = w_prev_ext + (w_diff <<< SHIFT);
    if (w_x_ext > c_sat_max) begin
      w_x_sat = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (w_x_ext < c_sat_min) begin
      w_x_sat = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      w_x_sat = w_x_ext[DATA_W-1:0];
    end
    w_is_null   = (S_AXIS_TKEEP == '0);
    w_beat_data = w_is_null ? '0 : w_x_sat;
  end

  // Handshake bookkeeping; ready is only high while the skid is empty, so an
  // accepted beat never finds the skid occupied
  always_comb begin
    w_accept          = S_AXIS_TVALID & r_s_ready;
    w_out_free        = ~r_out_valid | M_AXIS_TREADY;
    w_skid_valid_next = (w_accept & ~w_out_free) | (r_skid_valid & ~w_out_free);
  end

  // Decoder state advances at acceptance time; a packet end restarts from zero
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_y_prev <= '0;
    end else if (w_accept) begin
      if (S_AXIS_TLAST) begin
        r_y_prev <= '0;
      end else if (!w_is_null) begin
        r_y_prev <= S_AXIS_TDATA;
      end
    end
  end

  // Output register and skid: skid drains first, new beats bypass it when the
  // output stage can take them
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_keep   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_keep  <= '0;
      r_skid_last  <= 1'b0;
      r_s_ready    <= 1'b0;
    end else begin
      r_s_ready    <= ~w_skid_valid_next;
      r_skid_valid <= w_skid_valid_next;
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= r_skid_data;
          r_out_keep  <= r_skid_keep;
          r_out_last  <= r_skid_last;
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_beat_data;
          r_out_keep  <= S_AXIS_TKEEP;
          r_out_last  <= S_AXIS_TLAST;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_data <= w_beat_data;
        r_skid_keep <= S_AXIS_TKEEP;
        r_skid_last <= S_AXIS_TLAST;
      end
    end
  end

  assign S_AXIS_TREADY = r_s_ready;
  assign M_AXIS_TVALID = r_out_valid;
  assign M_AXIS_TDATA  = r_out_data;
  assign M_AXIS_TKEEP  = r_out_keep;
  assign M_AXIS_TLAST  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_axis_ema_inv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_ema_inv
//  Description : Scoreboard bench for axis_ema_inv (DATA_W=32, SHIFT=3).
//                Driver pushes expected beats at acceptance, monitor pops and
//                compares on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axis_ema_inv;

  localparam int SH = 3;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] S_AXIS_TDATA;
  logic [3:0]  S_AXIS_TKEEP;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;

  axis_ema_inv #(.DATA_W(32), .SHIFT(SH)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TKEEP  (S_AXIS_TKEEP),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  int     checks = 0;
  int     errors = 0;
  int     tries = 0;
  int     ready_mode = 2;   // 0: always ready, 1: random 50%, 2: never ready
  bit     mon_en = 0;
  longint yp = 0;           // reference decoder state
  beat_t  expq[$];

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: x = y_prev + (y - y_prev) * 2^SHIFT, clamped to 32-bit signed
  task automatic model_accept(input logic [31:0] y, input logic [3:0] k, input logic l,
                              input bit use_x, input logic [31:0] xe);
    beat_t  e;
    longint yv;
    longint xv;
    e.k = k;
    e.l = l;
    if (k == 4'h0) begin
      e.d = 32'h0;
    end else begin
      yv = longint'($signed(y));
      xv = yp + (yv - yp) * (longint'(1) << SH);
      if (xv > MAXV) xv = MAXV;
      else if (xv < MINV) xv = MINV;
      e.d = xv[31:0];
      yp = yv;
    end
    if (use_x) e.d = xe;
    if (l) yp = 0;
    expq.push_back(e);
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic drive_beat(input logic [31:0] y, input logic [3:0] k, input logic l,
                            input bit use_x, input logic [31:0] xe);
    bit acc = 0;
    int n = 0;
    S_AXIS_TDATA  = y;
    S_AXIS_TKEEP  = k;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    while (!acc) begin
      @(negedge ACLK);
      acc = S_AXIS_TREADY;
      tries++;
      @(posedge ACLK);
      #1;
      if (acc) begin
        model_accept(y, k, l, use_x, xe);
      end else begin
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout actual=no_accept required=accept");
          break;
        end
      end
    end
    S_AXIS_TVALID = 1'b0;
  endtask

  task automatic do_reset();
    S_AXIS_TVALID = 1'b0;
    mon_en = 0;
    ARESET = 1'b1;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    expq.delete();
    yp = 0;
    @(negedge ACLK);
    chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_m_tdata",  64'(M_AXIS_TDATA),  64'd0);
    chk("rst_m_tkeep",  64'(M_AXIS_TKEEP),  64'd0);
    chk("rst_m_tlast",  64'(M_AXIS_TLAST),  64'd0);
    chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
    @(negedge ACLK);
    chk("post_rst_s_tready", 64'(S_AXIS_TREADY), 64'd1);
    @(posedge ACLK);
    #1;
    mon_en = 1;
  endtask

  // Downstream ready generator
  initial begin
    M_AXIS_TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #1;
      case (ready_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
        default: M_AXIS_TREADY = 1'b0;
      endcase
    end
  end

  // Monitor: stall stability, skid occupancy and scoreboard compare
  initial begin
    bit          held = 0;
    logic [36:0] held_v = '0;
    beat_t       e;
    forever begin
      @(negedge ACLK);
      if (mon_en) begin
        if (held) begin
          chk("stall_tvalid", 64'(M_AXIS_TVALID), 64'd1);
          chk("stall_stable", 64'({M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST}), 64'(held_v));
        end
        chk("s_tready_vs_occupancy", 64'(S_AXIS_TREADY), 64'(expq.size() < 2));
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
          held = 0;
          if (expq.size() == 0) begin
            chk("unexpected_beat", 64'(M_AXIS_TDATA), 64'hDEAD);
          end else begin
            e = expq.pop_front();
            chk("tdata", 64'(M_AXIS_TDATA), 64'(e.d));
            chk("tkeep", 64'(M_AXIS_TKEEP), 64'(e.k));
            chk("tlast", 64'(M_AXIS_TLAST), 64'(e.l));
          end
        end else if (M_AXIS_TVALID) begin
          held = 1;
          held_v = {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TLAST};
        end else begin
          held = 0;
        end
      end else begin
        held = 0;
      end
    end
  end

  // Stimulus
  initial begin
    int     xs[4];
    longint enc;
    int     t0;
    int     tv;
    logic [31:0] y;
    logic [3:0]  k;

    S_AXIS_TDATA  = '0;
    S_AXIS_TKEEP  = '0;
    S_AXIS_TLAST  = 1'b0;
    S_AXIS_TVALID = 1'b0;
    ARESET        = 1'b1;
    #1;
    do_reset();
    ready_mode = 0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;

    // Basic sequence with one-cycle latency check on the first beat
    drive_beat(32'd0, 4'hF, 1'b0, 1, 32'd0);
    @(negedge ACLK);
    chk("latency_one_cycle", 64'(M_AXIS_TVALID), 64'd1);
    @(posedge ACLK); #1;
    drive_beat(32'd8, 4'hF, 1'b0, 1, 32'd64);
    drive_beat(32'd8, 4'hF, 1'b1, 1, 32'd8);

    // Saturation, each a one-beat packet from zero state
    drive_beat(32'h1000_0000, 4'hF, 1'b1, 1, 32'h7FFF_FFFF);
    drive_beat(32'hFFFF_FFF8, 4'hF, 1'b1, 1, 32'hFFFF_FFC0);
    drive_beat(32'hF000_0000, 4'hF, 1'b1, 1, 32'h8000_0000);

    // Packet boundary clears state
    drive_beat(32'd8, 4'hF, 1'b0, 1, 32'd64);
    drive_beat(32'd8, 4'hF, 1'b1, 1, 32'd8);
    drive_beat(32'd8, 4'hF, 1'b0, 1, 32'd64);
    drive_beat(32'd8, 4'hF, 1'b1, 1, 32'd8);

    // Null beats keep state; null with TLAST still clears it; partial keep passes
    drive_beat(32'd16,   4'hF, 1'b0, 1, 32'd128);
    drive_beat(32'd1234, 4'h0, 1'b0, 1, 32'd0);
    drive_beat(32'd24,   4'hF, 1'b0, 1, 32'd80);
    drive_beat(32'd7,    4'h0, 1'b1, 1, 32'd0);
    drive_beat(32'd8,    4'h3, 1'b1, 1, 32'd64);

    // Encoder chain: feed EMA-encoded samples
    xs = '{64, -40, 0, 1000};
    enc = 0;
    for (int i = 0; i < 4; i++) begin
      enc = enc + ((longint'(xs[i]) - enc) >>> SH);
      drive_beat(enc[31:0], 4'hF, 1'(i == 3), 0, 32'd0);
    end

    // Back-to-back burst with downstream always ready: one beat per cycle
    t0 = tries;
    for (int i = 0; i < 16; i++) begin
      drive_beat($urandom, 4'hF, 1'(i == 15), 0, 32'd0);
    end
    chk("burst_full_throughput", 64'(tries - t0), 64'd16);

    // Reset with two beats held internally
    ready_mode = 2;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    drive_beat(32'd100, 4'hF, 1'b0, 0, 32'd0);
    drive_beat(32'd200, 4'hF, 1'b0, 0, 32'd0);
    @(negedge ACLK);
    chk("skid_full_s_tready", 64'(S_AXIS_TREADY), 64'd0);
    @(posedge ACLK); #1;
    do_reset();
    ready_mode = 0;
    drive_beat(32'd8, 4'hF, 1'b1, 1, 32'd64);

    // Randomized traffic under random backpressure
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0: begin tv = int'($urandom_range(0, 511)) - 256; y = tv; end
        1: y = $urandom;
        2: y = $urandom & 32'hFFFF_0000;
        default: y = $urandom_range(0, 4095) * 8;
      endcase
      k = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      drive_beat(y, k, 1'($urandom_range(0, 7) == 0), 0, 32'd0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge ACLK); #1;
      end
    end

    // Drain
    ready_mode = 0;
    for (int i = 0; i < 200 && expq.size() != 0; i++) begin
      @(negedge ACLK);
    end
    @(negedge ACLK);
    chk("drain_empty", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
